// File: rtl/arbitro_rr4.sv
// arbitro_rr4: four-channel round-robin arbiter driving the select input of a
// 4-to-1 data mux. A granted source keeps the path for up to MAX_BURST
// transfers. The grant is held while the consumer stalls. On release, priority
// rotates to the source after the one that was granted, and the arbiter
// re-arbitrates in the same cycle so that no bubble appears.

module arbitro_rr4 #(
    parameter int MAX_BURST = 4,
    parameter int CW        = $clog2(MAX_BURST + 1)
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic [3:0]    Request,
    input  logic          Ready,
    output logic [1:0]    Selector,
    output logic [3:0]    Grant,
    output logic          Valid,
    output logic [CW-1:0] BurstCount
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_GRANTED = 1'b1
    } state_t;

    // Burst limit, widened by one bit so the incremented count can be compared against it
    localparam logic [CW:0] MAX_B = (CW + 1)'(MAX_BURST);

    state_t        state_q;
    logic [1:0]    ptr_q;
    logic [1:0]    sel_q;
    logic [3:0]    grant_q;
    logic          valid_q;
    logic [CW-1:0] burst_q;

    logic          xfer_s;
    logic          cont_s;
    logic [CW:0]   burst_inc_s;
    logic [1:0]    ptr_rel_s;
    logic [2:0]    pick_idle_s;
    logic [2:0]    pick_rel_s;

    // Round-robin scan starting at ptr. Returns {found, index}.
    // The loop runs from the highest offset down to offset 0, so the set bit
    // closest to ptr is written last and wins.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (req[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // One-hot decode of a mux index
    function automatic logic [3:0] onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    // Transfer detection, continue/release decision and both arbitration candidates
    always_comb begin
        xfer_s      = valid_q & Ready;
        burst_inc_s = {1'b0, burst_q} + {{CW{1'b0}}, 1'b1};
        cont_s      = Request[sel_q] && (burst_inc_s < MAX_B);
        ptr_rel_s   = sel_q + 2'd1;
        pick_idle_s = rr_pick(Request, ptr_q);
        pick_rel_s  = rr_pick(Request, ptr_rel_s);
    end

    // Grant FSM with registered mux select, grant, valid and burst count
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= 2'd0;
            sel_q   <= 2'd0;
            grant_q <= 4'b0000;
            valid_q <= 1'b0;
            burst_q <= {CW{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_idle_s[2]) begin
                        sel_q   <= pick_idle_s[1:0];
                        grant_q <= onehot(pick_idle_s[1:0]);
                        valid_q <= 1'b1;
                        burst_q <= {CW{1'b0}};
                        state_q <= ST_GRANTED;
                    end else begin
                        // Selector and the pointer hold while no source requests
                        grant_q <= 4'b0000;
                        valid_q <= 1'b0;
                    end
                end
                ST_GRANTED: begin
                    if (!xfer_s) begin
                        // Stalled: the grant is sticky and every output holds
                        state_q <= ST_GRANTED;
                    end else if (cont_s) begin
                        burst_q <= burst_inc_s[CW-1:0];
                    end else begin
                        ptr_q <= ptr_rel_s;
                        if (pick_rel_s[2]) begin
                            sel_q   <= pick_rel_s[1:0];
                            grant_q <= onehot(pick_rel_s[1:0]);
                            valid_q <= 1'b1;
                            burst_q <= {CW{1'b0}};
                        end else begin
                            // Selector holds its last value while idle
                            grant_q <= 4'b0000;
                            valid_q <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= 4'b0000;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign Selector   = sel_q;
    assign Grant      = grant_q;
    assign Valid      = valid_q;
    assign BurstCount = burst_q;

endmodule

// File: tb/tb_arbitro_rr4.sv
// Bench for arbitro_rr4. Two instances share the same stimulus: one with
// MAX_BURST=4 and one with MAX_BURST=1. A behavioural model predicts every
// cycle, pushes its expectations to scoreboard queues, and the expectations are
// popped and compared after each edge. Directed checks against constant
// sequences are added on top.

module tb_arbitro_rr4;

    logic       clk;
    logic       Reset;
    logic [3:0] Request;
    logic       Ready;

    logic [1:0] sel4, sel1;
    logic [3:0] gnt4, gnt1;
    logic       val4, val1;
    logic [2:0] bc4;
    logic [0:0] bc1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int st;
        int ptr;
        int sel;
        int grant;
        int valid;
        int bc;
    } mstate_t;

    mstate_t m4, m1;
    mstate_t q4[$];
    mstate_t q1[$];

    arbitro_rr4 #(.MAX_BURST(4)) dut4 (
        .Clock(clk), .Reset(Reset), .Request(Request), .Ready(Ready),
        .Selector(sel4), .Grant(gnt4), .Valid(val4), .BurstCount(bc4)
    );

    arbitro_rr4 #(.MAX_BURST(1)) dut1 (
        .Clock(clk), .Reset(Reset), .Request(Request), .Ready(Ready),
        .Selector(sel1), .Grant(gnt1), .Valid(val1), .BurstCount(bc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] req, input int ptr);
        for (int k = 0; k < 4; k++) begin
            if (req[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    function automatic mstate_t model_next(input mstate_t s, input int maxb, input logic rst,
                                           input logic [3:0] req, input logic rdy);
        mstate_t n;
        int w;
        n = s;
        if (rst) begin
            n = '{0, 0, 0, 0, 0, 0};
        end else if (s.st == 0) begin
            w = pick(req, s.ptr);
            if (w >= 0) begin
                n.st = 1; n.sel = w; n.grant = 1 << w; n.valid = 1; n.bc = 0;
            end
        end else if (rdy) begin
            if (req[s.sel] && (s.bc + 1 < maxb)) begin
                n.bc = s.bc + 1;
            end else begin
                n.ptr = (s.sel + 1) % 4;
                w = pick(req, n.ptr);
                if (w >= 0) begin
                    n.sel = w; n.grant = 1 << w; n.bc = 0;
                end else begin
                    n.st = 0; n.valid = 0; n.grant = 0;
                end
            end
        end
        return n;
    endfunction

    // Drive one cycle, predict, then compare both instances after the edge
    task automatic step(input logic [3:0] req, input logic rdy, input logic rst);
        mstate_t e;
        @(negedge clk);
        Request = req;
        Ready   = rdy;
        Reset   = rst;
        m4 = model_next(m4, 4, rst, req, rdy);
        m1 = model_next(m1, 1, rst, req, rdy);
        q4.push_back(m4);
        q1.push_back(m1);
        @(posedge clk);
        #1;
        e = q4.pop_front();
        check("d4_sel",   32'(sel4), 32'(e.sel));
        check("d4_grant", 32'(gnt4), 32'(e.grant));
        check("d4_valid", 32'(val4), 32'(e.valid));
        check("d4_bc",    32'(bc4),  32'(e.bc));
        e = q1.pop_front();
        check("d1_sel",   32'(sel1), 32'(e.sel));
        check("d1_grant", 32'(gnt1), 32'(e.grant));
        check("d1_valid", 32'(val1), 32'(e.valid));
        check("d1_bc",    32'(bc1),  32'(e.bc));
    endtask

    initial begin
        int rr_seq[3];
        logic [3:0] rq;
        logic       rd;
        logic       rs;
        rr_seq  = '{0, 1, 3};
        m4      = '{0, 0, 0, 0, 0, 0};
        m1      = '{0, 0, 0, 0, 0, 0};
        Request = 4'b0000;
        Ready   = 1'b0;
        Reset   = 1'b1;

        // Reset held with all requests and Ready high
        for (int i = 0; i < 3; i++) begin
            step(4'b1111, 1'b1, 1'b1);
            check("rst_sel",   32'(sel4), 32'd0);
            check("rst_grant", 32'(gnt4), 32'd0);
            check("rst_valid", 32'(val4), 32'd0);
            check("rst_bc",    32'(bc4),  32'd0);
        end

        // Burst rotation, MAX_BURST=4; the first sample is the grant one cycle after reset drops
        for (int k = 0; k < 20; k++) begin
            step(4'b1111, 1'b1, 1'b0);
            check("rot_sel",   32'(sel4), 32'((k / 4) % 4));
            check("rot_bc",    32'(bc4),  32'(k % 4));
            check("rot_valid", 32'(val4), 32'd1);
            check("rot_grant", 32'(gnt4), 32'(1 << ((k / 4) % 4)));
        end

        // Pure round-robin on the MAX_BURST=1 instance
        step(4'b0000, 1'b0, 1'b1);
        for (int k = 0; k < 9; k++) begin
            step(4'b1011, 1'b1, 1'b0);
            check("rr_sel",   32'(sel1), 32'(rr_seq[k % 3]));
            check("rr_valid", 32'(val1), 32'd1);
        end

        // Backpressure: grant source 2, stall and drop its request, then release to idle
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0100, 1'b0, 1'b0);
        check("bp_sel0", 32'(sel4), 32'd2);
        for (int i = 0; i < 5; i++) begin
            step((i < 2) ? 4'b0100 : 4'b0000, 1'b0, 1'b0);
            check("bp_sel",   32'(sel4), 32'd2);
            check("bp_grant", 32'(gnt4), 32'h4);
            check("bp_valid", 32'(val4), 32'd1);
            check("bp_bc",    32'(bc4),  32'd0);
        end
        step(4'b0000, 1'b1, 1'b0);
        check("bp_idle_valid", 32'(val4), 32'd0);
        check("bp_idle_grant", 32'(gnt4), 32'd0);
        check("bp_idle_sel",   32'(sel4), 32'd2);

        // Lone requester wraps back onto itself without a bubble
        step(4'b0000, 1'b0, 1'b1);
        for (int k = 0; k < 9; k++) begin
            step(4'b0010, 1'b1, 1'b0);
            check("lone_sel",   32'(sel4), 32'd1);
            check("lone_valid", 32'(val4), 32'd1);
            check("lone_bc",    32'(bc4),  32'(k % 4));
        end

        // Reset mid-burst at Selector=2, BurstCount=1
        step(4'b0000, 1'b0, 1'b1);
        for (int k = 0; k < 10; k++) begin
            step(4'b1111, 1'b1, 1'b0);
        end
        check("mid_pre_sel", 32'(sel4), 32'd2);
        check("mid_pre_bc",  32'(bc4),  32'd1);
        step(4'b1111, 1'b1, 1'b1);
        check("mid_rst_sel",   32'(sel4), 32'd0);
        check("mid_rst_valid", 32'(val4), 32'd0);
        check("mid_rst_bc",    32'(bc4),  32'd0);
        step(4'b1111, 1'b1, 1'b0);
        check("mid_post_sel",   32'(sel4), 32'd0);
        check("mid_post_grant", 32'(gnt4), 32'd1);
        check("mid_post_valid", 32'(val4), 32'd1);

        // Random traffic with occasional reset
        for (int k = 0; k < 400; k++) begin
            rq = 4'($urandom_range(0, 15));
            rd = 1'($urandom_range(0, 3) != 0);
            rs = 1'($urandom_range(0, 63) == 0);
            step(rq, rd, rs);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/arbitro_rr4.md
# arbitro_rr4

Four-channel round-robin arbiter that sits directly upstream of the 4-to-1 data multiplexer and drives its `Selector` input. Each of four sources raises a request. The arbiter grants one source at a time and holds the mux select stable while the downstream consumer applies backpressure. It also lets a granted source keep the path for a bounded burst of transfers before rotating priority.

## Interface
- `MAX_BURST`, default 4: maximum consecutive transfers per grant. Legal values are 1 to 15.
- `CW`, default `$clog2(MAX_BURST+1)`: burst counter width. Derived; do not override.
- `Clock`: input, 1 bit. The single clock; all state updates on its rising edge.
- `Reset`: input, 1 bit. Synchronous, active-high.
- `Request`: input, 4 bits. Per-source request; bit i belongs to mux input i.
- `Ready`: input, 1 bit. Downstream accepts the mux output this cycle.
- `Selector`: output, 2 bits. Index of the granted source; connects to the mux `Selector`.
- `Grant`: output, 4 bits. One-hot grant, `Grant[Selector]` is 1; all zero when idle.
- `Valid`: output, 1 bit. Mux output carries a granted word.
- `BurstCount`: output, `CW` bits. Transfers completed in the current grant.

## Operation
- Reset values, applied on the first edge with `Reset`=1 regardless of other inputs:
  - `Selector`=0, `Grant`=0, `Valid`=0, `BurstCount`=0.
  - Internal priority pointer `Ptr`=0.
  - State is IDLE.
- States are IDLE and GRANTED.
- Transfer: a cycle with `Valid`=1 and `Ready`=1.
- Arbitration function: scan `Request` starting at `Ptr` in the order Ptr, Ptr+1, Ptr+2, Ptr+3, with indices mod 4. The first set bit wins.
- IDLE:
  - If `Request`≠0, arbitrate. Register the winner into `Selector` and `Grant` (one-hot), set `Valid`=1 and `BurstCount`=0, and go to GRANTED.
  - Otherwise stay in IDLE and hold `Selector` at its last value.
- GRANTED with no transfer (`Ready`=0): hold every output and `Ptr` unchanged. The grant is sticky: deasserting `Request[Selector]` is ignored until a transfer happens.
- GRANTED with a transfer:
  - Continue if `Request[Selector]`=1 and `BurstCount`+1 < `MAX_BURST`. `BurstCount` increments; `Selector`, `Grant`, `Valid` and `Ptr` are unchanged.
  - Otherwise release:
    - `Ptr` becomes `Selector`+1 mod 4, wrapping 3 to 0.
    - Re-arbitrate in the same cycle using the new `Ptr` and the current `Request`.
    - If there is a winner, load it with `BurstCount`=0, keep `Valid`=1 and stay in GRANTED. This gives no bubble. The releasing source may win again only if no other source requests.
    - If there is no winner, go to IDLE with `Valid`=0 and `Grant`=0; `Selector` holds.
- `BurstCount` never exceeds `MAX_BURST`-1. With `MAX_BURST`=1 the arbiter rotates after every transfer.
- `Grant` always equals the one-hot decode of `Selector` when `Valid`=1, and is 0 when `Valid`=0.

## Timing
- All outputs are registered, with no combinational path from inputs to outputs.
- Latency from IDLE: `Request` seen high at edge N gives `Valid`, `Selector` and `Grant` at edge N+1.
- Back-to-back handoff: a transfer at edge N that releases gives the new source on the mux at edge N+1, with `Valid` continuously 1.
- `Selector` changes only at a release or on an IDLE-to-GRANTED load. It is stable for the whole of every cycle in which `Valid`=1 and `Ready`=0.
- Reset asserted mid-burst: the next edge forces the reset values, discarding any pending transfer and the pointer. The first grant after `Reset` deasserts follows the IDLE latency rule.
- Simultaneous `Reset` and a transfer: `Reset` wins.

## Test plan
- Reset: hold `Request`=1111 and `Ready`=1 with `Reset`=1 for 3 cycles. Required: `Selector`=0, `Grant`=0000, `Valid`=0, `BurstCount`=0. One cycle after `Reset` drops, `Selector`=0, `Grant`=0001, `Valid`=1.
- Burst rotation (`MAX_BURST`=4): `Request`=1111, `Ready`=1 continuously. Required: `Selector` reads 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0…, `BurstCount` reads 0,1,2,3 repeating, and `Valid` never drops.
- Pure round-robin (`MAX_BURST`=1): `Request`=1011, `Ready`=1. Required: `Selector` reads 0,1,3,0,1,3… with channel 2 never granted.
- Backpressure: grant source 2, then hold `Ready`=0 for 5 cycles and drop `Request[2]` during that window. Required: `Selector`=2, `Grant`=0100, `Valid`=1 and `BurstCount` are constant. On `Ready`=1 the transfer releases. If `Request`=0, the next cycle shows `Valid`=0, `Grant`=0000 and `Selector`=2 held.
- Lone requester wrap: `Request`=0010, `Ready`=1, `MAX_BURST`=4. Required: after 4 transfers `Ptr` becomes 2 and source 1 is re-granted with no `Valid` bubble and `BurstCount` back to 0.
- Reset mid-burst: with `Request`=1111, `Ready`=1, assert `Reset` for 1 cycle when `Selector`=2 and `BurstCount`=1. Required: reset values on the next edge, then grant source 0 one cycle after release.
